// File: rtl/countdown3.sv
// Loadable down-counter that drains a budget by STEP per accepted decrement,
// saturating at zero and flagging when the final decrement overshot.
module countdown3 #(
  parameter int WIDTH = 32,
  parameter int STEP  = 3
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  input  logic             abort,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             underflow,
  output logic [WIDTH-1:0] ticks
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] value_nxt, ticks_nxt;
  logic             underflow_nxt;

  // Compare-guarded subtraction: never wraps below zero.
  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] v);
    return (v > STEP_W) ? (v - STEP_W) : '0;
  endfunction

  function automatic logic overshoots(input logic [WIDTH-1:0] v);
    return (v < STEP_W);
  endfunction

  always_comb begin
    state_nxt     = state;
    value_nxt     = value;
    ticks_nxt     = ticks;
    underflow_nxt = underflow;
    unique case (state)
      IDLE: begin
        if (!abort && load) begin
          value_nxt     = load_value;
          ticks_nxt     = '0;
          underflow_nxt = 1'b0;
          state_nxt     = (load_value != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (load) begin
          value_nxt     = load_value;
          ticks_nxt     = '0;
          underflow_nxt = 1'b0;
          state_nxt     = (load_value != '0) ? RUN : DONE;
        end else if (dec) begin
          ticks_nxt = ticks + 1'b1;
          value_nxt = sat_step(value);
          if (value <= STEP_W) begin
            state_nxt = DONE;
            if (overshoots(value)) underflow_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (!abort && load) begin
          value_nxt     = load_value;
          ticks_nxt     = '0;
          underflow_nxt = 1'b0;
          state_nxt     = (load_value != '0) ? RUN : DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registers update on the falling edge of clock.
  always_ff @(negedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      value     <= '0;
      ticks     <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      value     <= value_nxt;
      ticks     <= ticks_nxt;
      underflow <= underflow_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (value == '0);

endmodule

// File: tb/tb_countdown3.sv
// Scoreboard bench for countdown3: each driven cycle pushes its expected
// outputs, which are popped and compared after the falling edge.
module tb_countdown3;

  localparam int W = 32;

  logic         clock, clear_n, load, dec, abort;
  logic [W-1:0] load_value;
  logic [W-1:0] value, ticks;
  logic         busy, done, zero, underflow;

  typedef struct packed {
    logic [W-1:0] value;
    logic         busy;
    logic         done;
    logic         zero;
    logic         uf;
    logic [W-1:0] ticks;
  } obs_t;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         dc;
    logic         ab;
    obs_t         exp;
  } row_t;

  obs_t sb[$];
  int   tests = 0;
  int   fails = 0;

  countdown3 #(.WIDTH(W), .STEP(3)) dut (
    .clock(clock), .clear_n(clear_n), .load(load), .load_value(load_value),
    .dec(dec), .abort(abort), .value(value), .busy(busy), .done(done),
    .zero(zero), .underflow(underflow), .ticks(ticks)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  function automatic obs_t o(input int v, input bit b, input bit d, input bit uf, input int t);
    obs_t r;
    r.value = W'(v);
    r.busy  = b;
    r.done  = d;
    r.zero  = (v == 0);
    r.uf    = uf;
    r.ticks = W'(t);
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.value = value;
    r.busy  = busy;
    r.done  = done;
    r.zero  = zero;
    r.uf    = underflow;
    r.ticks = ticks;
    return r;
  endfunction

  function automatic row_t rw(input bit ld, input int lv, input bit dc, input bit ab, input obs_t e);
    row_t r;
    r.ld = ld; r.lv = W'(lv); r.dc = dc; r.ab = ab; r.exp = e;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, advance past the edge.
  task automatic drive(input row_t r);
    load = r.ld; load_value = r.lv; dec = r.dc; abort = r.ab;
    sb.push_back(r.exp);
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    clear_n = 1'b0; load = 0; load_value = '0; dec = 0; abort = 0;
    #2;
    sb.push_back(o(0, 0, 0, 0, 0));
    e = sb.pop_front(); g = sample(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset_state got=%h expected=%h", g, e);
    end
    @(posedge clock); #1;
    clear_n = 1'b1;
    drive(rw(0, 0, 1, 0, o(0, 0, 0, 0, 0)));
    e = sb.pop_front(); g = sample(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL reset_idle_dec got=%h expected=%h", g, e);
    end
  endtask

  task automatic test_exact_run();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 9, 0, 0, o(9, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(6, 1, 0, 0, 1)),
             rw(0, 0, 1, 0, o(3, 1, 0, 0, 2)), rw(0, 0, 1, 0, o(0, 0, 1, 0, 3)),
             rw(0, 0, 1, 0, o(0, 0, 0, 0, 3)), rw(0, 0, 1, 0, o(0, 0, 0, 0, 3))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL exact_run step %0d got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_overshoot();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 10, 0, 0, o(10, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(7, 1, 0, 0, 1)),
             rw(0, 0, 1, 0, o(4, 1, 0, 0, 2)),   rw(0, 0, 1, 0, o(1, 1, 0, 0, 3)),
             rw(0, 0, 1, 0, o(0, 0, 1, 1, 4)),   rw(0, 0, 0, 0, o(0, 0, 0, 1, 4)),
             rw(1, 5, 0, 0, o(5, 1, 0, 0, 0)),   rw(0, 0, 0, 1, o(5, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL overshoot step %0d got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_zero_and_gaps();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 0, 0, 0, o(0, 0, 1, 0, 0)), rw(0, 0, 1, 0, o(0, 0, 0, 0, 0)),
             rw(1, 6, 0, 0, o(6, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(3, 1, 0, 0, 1)),
             rw(0, 0, 0, 0, o(3, 1, 0, 0, 1)), rw(0, 0, 0, 0, o(3, 1, 0, 0, 1)),
             rw(0, 0, 1, 0, o(0, 0, 1, 0, 2)), rw(0, 0, 0, 0, o(0, 0, 0, 0, 2))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL zero_and_gaps step %0d got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_abort_restart();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 12, 0, 0, o(12, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(9, 1, 0, 0, 1)),
             rw(0, 0, 1, 0, o(6, 1, 0, 0, 2)),   rw(0, 0, 1, 1, o(6, 0, 0, 0, 2)),
             rw(0, 0, 1, 0, o(6, 0, 0, 0, 2)),   rw(1, 12, 0, 0, o(12, 1, 0, 0, 0)),
             rw(0, 0, 1, 0, o(9, 1, 0, 0, 1)),   rw(1, 4, 1, 0, o(4, 1, 0, 0, 0)),
             rw(1, 7, 1, 1, o(4, 0, 0, 0, 0)),   rw(1, 7, 0, 1, o(4, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL abort_restart step %0d got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_load_in_done();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 2, 0, 0, o(2, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(0, 0, 1, 1, 1)),
             rw(1, 3, 0, 0, o(3, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(0, 0, 1, 0, 1)),
             rw(1, 5, 0, 1, o(0, 0, 0, 0, 1)), rw(0, 0, 0, 0, o(0, 0, 0, 0, 1))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL load_in_done step %0d got=%h expected=%h", i, g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    obs_t e, g;
    rows = '{rw(1, 30, 0, 0, o(30, 1, 0, 0, 0)), rw(0, 0, 1, 0, o(27, 1, 0, 0, 1)),
             rw(0, 0, 1, 0, o(24, 1, 0, 0, 2)),  rw(0, 0, 1, 0, o(21, 1, 0, 0, 3))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL async_reset run step %0d got=%h expected=%h", i, g, e);
      end
    end
    // Pull reset between edges; the clear must be visible before any edge.
    @(posedge clock); #1;
    clear_n = 1'b0; dec = 1'b1; load = 1'b0;
    #1;
    sb.push_back(o(0, 0, 0, 0, 0));
    e = sb.pop_front(); g = sample(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL async_reset_immediate got=%h expected=%h", g, e);
    end
    @(negedge clock); #1;
    sb.push_back(o(0, 0, 0, 0, 0));
    e = sb.pop_front(); g = sample(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL async_reset_dec_held got=%h expected=%h", g, e);
    end
    @(posedge clock); #1;
    clear_n = 1'b1; dec = 1'b0;
    rows = '{rw(0, 0, 1, 0, o(0, 0, 0, 0, 0)), rw(1, 1, 0, 0, o(1, 1, 0, 0, 0)),
             rw(0, 0, 1, 0, o(0, 0, 1, 1, 1))};
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front(); g = sample(); tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL async_reset rerun step %0d got=%h expected=%h", i, g, e);
      end
    end
    // Reset while in DONE with underflow set: no done, sticky flag cleared.
    @(posedge clock); #1;
    clear_n = 1'b0; dec = 1'b0;
    #1;
    sb.push_back(o(0, 0, 0, 0, 0));
    e = sb.pop_front(); g = sample(); tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL async_reset_in_done got=%h expected=%h", g, e);
    end
    @(posedge clock); #1;
    clear_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_exact_run();
    test_overshoot();
    test_zero_and_gaps();
    test_abort_restart();
    test_load_in_done();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown3.md
# countdown3

Loadable down-counter that consumes counts: it decrements a loaded value by a fixed step on each enabled clock and reports completion. It is the draining counterpart to the up-by-step counter register. A producer loads a budget, `dec` strobes spend it, and `done` tells the consumer when the budget reaches zero. The block saturates at zero and never wraps below it. It flags when the final step overshot.

## Interface
- `WIDTH`, 32, width of loaded value, `value` and `ticks`
- `STEP`, 3, amount subtracted per accepted decrement; must satisfy 1 ≤ STEP < 2^WIDTH
- `clock`  in  1  system clock; all registers update on the falling edge
- `clear_n`  in  1  reset, asynchronous, active-low
- `load`  in  1  load `load_value` and start a countdown
- `load_value`  in  WIDTH  starting count
- `dec`  in  1  decrement enable, sampled only in RUN
- `abort`  in  1  stop the countdown and return to IDLE, keeping `value`
- `value`  out  WIDTH  current remaining count
- `busy`  out  1  high while in RUN
- `done`  out  1  high for exactly one cycle, in DONE
- `zero`  out  1  combinational, high when `value == 0`
- `underflow`  out  1  sticky; the final decrement had `value < STEP`
- `ticks`  out  WIDTH  number of decrements accepted since the last load

## Operation
- States are IDLE, RUN and DONE.
  - `busy` = (state == RUN).
  - `done` = (state == DONE).
- Priority on each edge, highest first: `abort`, `load`, `dec`.
- **IDLE**
  - `load`: `value` ← `load_value`; `ticks` ← 0; `underflow` ← 0.
  - If `load_value` ≠ 0, go to RUN. If `load_value` == 0, go to DONE.
  - `dec` is ignored in IDLE.
- **RUN, `abort`**: go to IDLE. `value`, `ticks` and `underflow` hold. `done` is not asserted.
- **RUN, `load`**: restart exactly as from IDLE, discarding any in-progress count.
- **RUN, `dec`**, with `ticks` ← `ticks` + 1 in every case:
  - If `value` > STEP: `value` ← `value` − STEP; stay in RUN.
  - If `value` == STEP: `value` ← 0; go to DONE; `underflow` stays 0.
  - If `value` < STEP: `value` ← 0; `underflow` ← 1; go to DONE.
- **RUN, no `dec`**: hold everything.
- **DONE**: unconditionally leave after one cycle.
  - `load` present: perform a load; next state per the IDLE rules.
  - Otherwise go to IDLE.
  - `abort` in DONE goes to IDLE and suppresses any `load`.
  - `done` is high for this cycle regardless of input.
- **Arithmetic**
  - The subtraction is WIDTH bits wide and is guarded by the compare, so it never wraps.
  - `ticks` is WIDTH bits and wraps modulo 2^WIDTH. Overflow is unreachable in practice and is not flagged.
- **Reset** (`clear_n` low), immediate and independent of `clock`:
  - state = IDLE, `value` = 0, `ticks` = 0, `underflow` = 0.
  - Therefore `busy` = 0, `done` = 0, `zero` = 1.
  - Reset mid-RUN or in DONE discards the countdown with no `done` pulse.

## Timing
- All sampling and updates occur on the falling edge of `clock`. Outputs change only after that edge or on the assertion of `clear_n`.
- Load accepted at edge k: `value`, `busy` and `ticks` = 0 are visible after edge k.
- With `dec` held high from edge k+1: the last decrement lands on edge k + ceil(V/STEP).
  - `done` is high from that edge until the next one.
  - `busy` falls on the same edge that `done` rises.
- Load of 0 at edge k: `done` is high between edges k and k+1.
- Release of `clear_n` is not synchronised internally. The bench changes `clear_n` only while `clock` is high.
- `zero` follows `value` combinationally with no added latency.

## Test plan
- **Exact run**: reset, load 9, `dec` held -> `value` 9, 6, 3, 0; `done` is one cycle wide at the 0; `underflow` 0; `ticks` 3; then IDLE with `zero` 1.
- **Overshoot run**: load 10, `dec` held -> `value` 10, 7, 4, 1, 0; `underflow` 1; `ticks` 4; a new load of 5 clears `underflow` to 0.
- **Zero load and gaps**:
  - Load 0 -> `done` high for the next cycle, `busy` never high, `ticks` 0.
  - Load 6 with `dec` pattern 1, 0, 0, 1 -> `value` 6, 3, 3, 3, 0; `done` after the fourth edge.
- **Abort and restart**:
  - Load 12, two decs (value 6), then `abort` -> IDLE; `value` 6, `ticks` 2, no `done`.
  - Load 12, one dec, then `load` 4 -> `value` 4, `ticks` 0, still RUN.
  - `abort` + `load` on the same edge -> IDLE, `value` unchanged.
- **Load in DONE**: after `done` rises, assert `load` 3 in that cycle -> next state RUN with `value` 3, then `done` again after one dec.
- **Async reset mid-count**: load 30, three decs (value 21), pull `clear_n` low between edges -> immediately `value` 0, `busy` 0, `ticks` 0, `underflow` 0, no `done`; `dec` during reset has no effect.
